// File: rtl/gol_pkg.sv
// Shared constants, scan-state encoding and a row-slice helper for the
// Game-of-Life display path.
package gol_pkg;

    localparam int GRID_W = 64;
    localparam int ROWS   = 8;
    localparam int COLS   = 8;
    localparam int ROW_W  = $clog2(ROWS);

    // Scan sequencer states: wait for the first generation, latch it into the
    // display buffer, drive one row, blank between rows.
    typedef enum logic [1:0] {
        SCAN_IDLE,
        SCAN_LOAD,
        SCAN_DRIVE,
        SCAN_GAP
    } scan_state_t;

    // Column bits of one matrix row; bit r*COLS+c of the grid is row r, column c.
    function automatic logic [COLS-1:0] grid_row(input logic [GRID_W-1:0] g,
                                                 input logic [ROW_W-1:0]  r);
        return g[int'(r) * COLS +: COLS];
    endfunction

endpackage

// File: rtl/row_timer.sv
// Loadable down-counter timing both the row dwell and the inter-row gap.
// Loading len makes done assert on the len-th cycle after the load.
module row_timer #(
    parameter int MAX_LEN = 2,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [LEN_W-1:0] len,
    output logic             done
);

    localparam int CNT_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    logic [CNT_W-1:0] cnt;

    // Count down from len-1 and park at zero until the next load.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others; blocking here would create ordering races.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CNT_W'(len - LEN_W'(1));
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/grid_display_scan.sv
// Captures committed Game-of-Life generations and row-scans them onto an
// LED matrix. The display buffer only reloads between frames, so a frame
// never shows rows from two different generations.
module grid_display_scan
    import gol_pkg::*;
#(
    parameter int DWELL = 1024,
    parameter int GAP   = 2,
    parameter int GEN_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [GRID_W-1:0] grid,
    input  logic              grid_valid,
    input  logic              blank,
    output logic [ROWS-1:0]   row_sel,
    output logic [COLS-1:0]   col_data,
    output logic              frame_done,
    output logic [GEN_W-1:0]  gen_count,
    output logic              still,
    output logic              extinct
);

    localparam int MAX_LEN = (DWELL > GAP) ? DWELL : GAP;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    scan_state_t       state, state_nxt;
    logic [ROW_W-1:0]  row, row_nxt;
    logic [GRID_W-1:0] pend_buf;
    logic [GRID_W-1:0] disp_buf;
    logic              pend_ok;
    logic              disp_load;

    logic              tmr_load;
    logic [LEN_W-1:0]  tmr_len;
    logic              tmr_done;

    logic [ROWS-1:0]   row_sel_nxt;
    logic [COLS-1:0]   col_data_nxt;
    logic              frame_done_nxt;

    row_timer #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_row_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (tmr_load),
        .len     (tmr_len),
        .done    (tmr_done)
    );

    // Sequencer state and current row index.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SCAN_IDLE;
            row   <= '0;
        end else begin
            state <= state_nxt;
            row   <= row_nxt;
        end
    end

    // Next state, timer reloads and the drive values for the coming cycle.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned; a missing default here would infer a latch.
    always_comb begin
        state_nxt      = state;
        row_nxt        = row;
        tmr_load       = 1'b0;
        tmr_len        = LEN_W'(DWELL);
        disp_load      = 1'b0;
        row_sel_nxt    = '1;
        col_data_nxt   = '0;
        frame_done_nxt = 1'b0;

        unique case (state)
            SCAN_IDLE: begin
                if (grid_valid) begin
                    state_nxt = SCAN_LOAD;
                end
            end

            SCAN_LOAD: begin
                disp_load = 1'b1;
                row_nxt   = '0;
                tmr_load  = 1'b1;
                state_nxt = SCAN_DRIVE;
            end

            SCAN_DRIVE: begin
                if (!blank) begin
                    row_sel_nxt[row] = 1'b0;
                    col_data_nxt     = grid_row(disp_buf, row);
                end
                if (tmr_done) begin
                    tmr_load  = 1'b1;
                    tmr_len   = LEN_W'(GAP);
                    state_nxt = SCAN_GAP;
                end
            end

            SCAN_GAP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (row == ROW_W'(ROWS - 1)) begin
                        frame_done_nxt = 1'b1;
                        if (pend_ok) begin
                            state_nxt = SCAN_LOAD;
                        end else begin
                            row_nxt   = '0;
                            state_nxt = SCAN_DRIVE;
                        end
                    end else begin
                        row_nxt   = row + ROW_W'(1);
                        state_nxt = SCAN_DRIVE;
                    end
                end
            end

            default: state_nxt = SCAN_IDLE;
        endcase
    end

    // Register the matrix drive so the pins switch cleanly one cycle after
    // the sequencer moves.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_sel    <= '1;
            col_data   <= '0;
            frame_done <= 1'b0;
        end else begin
            row_sel    <= row_sel_nxt;
            col_data   <= col_data_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Generation capture, status flags and the frame-boundary buffer swap.
    // A capture in the same cycle as a swap keeps pend_ok set so the new grid
    // shows on the following frame.
    // NOTE: the grid buffers are ordinary flops, not a RAM, so they are reset
    // like any other state; a blank screen after reset depends on it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_buf  <= '0;
            disp_buf  <= '0;
            pend_ok   <= 1'b0;
            gen_count <= '0;
            still     <= 1'b0;
            extinct   <= 1'b0;
        end else begin
            if (disp_load) begin
                disp_buf <= pend_buf;
                pend_ok  <= 1'b0;
            end
            if (grid_valid) begin
                pend_buf <= grid;
                pend_ok  <= 1'b1;
                still    <= (grid == pend_buf);
                extinct  <= (grid == '0);
                if (gen_count != '1) begin
                    gen_count <= gen_count + GEN_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_grid_display_scan.sv
// Scoreboard bench for grid_display_scan. A frame-position reference model
// pushes the expected outputs for every clock edge; a negedge monitor pops
// and compares them against the DUT.
module tb_grid_display_scan;

    localparam int DWELL  = 4;
    localparam int GAP    = 1;
    localparam int GEN_W  = 2;
    localparam int NROWS  = 8;
    localparam int NCOLS  = 8;
    localparam int PER    = DWELL + GAP;
    localparam int FRAME  = NROWS * PER;
    localparam int GENMAX = (1 << GEN_W) - 1;
    localparam int SLOT_IDLE = -2;
    localparam int SLOT_LOAD = -1;

    logic             clk;
    logic             reset_n;
    logic [63:0]      grid;
    logic             grid_valid;
    logic             blank;
    logic [NROWS-1:0] row_sel;
    logic [NCOLS-1:0] col_data;
    logic             frame_done;
    logic [GEN_W-1:0] gen_count;
    logic             still;
    logic             extinct;

    int n_cmp = 0;
    int n_mis = 0;

    grid_display_scan #(
        .DWELL (DWELL),
        .GAP   (GAP),
        .GEN_W (GEN_W)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .grid       (grid),
        .grid_valid (grid_valid),
        .blank      (blank),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done),
        .gen_count  (gen_count),
        .still      (still),
        .extinct    (extinct)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NROWS-1:0] rs;
        logic [NCOLS-1:0] cd;
        logic             fd;
        logic [GEN_W-1:0] gen;
        logic             st;
        logic             ex;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: frame position arithmetic, evaluated once per edge.
    logic [63:0] m_pend    = '0;
    logic [63:0] m_disp    = '0;
    bit          m_pend_ok = 1'b0;
    int          m_slot    = SLOT_IDLE;
    int          m_gen     = 0;
    bit          m_still   = 1'b0;
    bit          m_ext     = 1'b0;

    always @(posedge clk) begin
        exp_t e;
        int   r;
        int   off;
        if (!reset_n) begin
            m_pend    = '0;
            m_disp    = '0;
            m_pend_ok = 1'b0;
            m_slot    = SLOT_IDLE;
            m_gen     = 0;
            m_still   = 1'b0;
            m_ext     = 1'b0;
        end else begin
            e.rs = '1;
            e.cd = '0;
            e.fd = 1'b0;
            if (m_slot == SLOT_IDLE) begin
                if (grid_valid) m_slot = SLOT_LOAD;
            end else if (m_slot == SLOT_LOAD) begin
                m_disp    = m_pend;
                m_pend_ok = 1'b0;
                m_slot    = 0;
            end else begin
                r   = m_slot / PER;
                off = m_slot % PER;
                if (off < DWELL && !blank) begin
                    e.rs = ~(8'h01 << r);
                    e.cd = m_disp[r*NCOLS +: NCOLS];
                end
                if (m_slot == FRAME - 1) begin
                    e.fd   = 1'b1;
                    m_slot = m_pend_ok ? SLOT_LOAD : 0;
                end else begin
                    m_slot++;
                end
            end
            if (grid_valid) begin
                m_still   = (grid == m_pend);
                m_ext     = (grid == 64'h0);
                m_pend    = grid;
                m_pend_ok = 1'b1;
                if (m_gen < GENMAX) m_gen++;
            end
            e.gen = GEN_W'(m_gen);
            e.st  = m_still;
            e.ex  = m_ext;
            exp_q.push_back(e);
        end
    end

    // Monitor: compare the outputs presented after each edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("row_sel",    64'(row_sel),    64'(e.rs));
            check("col_data",   64'(col_data),   64'(e.cd));
            check("frame_done", 64'(frame_done), 64'(e.fd));
            check("gen_count",  64'(gen_count),  64'(e.gen));
            check("still",      64'(still),      64'(e.st));
            check("extinct",    64'(extinct),    64'(e.ex));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [63:0] g);
        @(negedge clk);
        grid       = g;
        grid_valid = 1'b1;
        @(negedge clk);
        grid_valid = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int k    = 0;
        bit seen = 1'b0;
        while (k < budget && !seen) begin
            @(negedge clk);
            k++;
            if (frame_done) seen = 1'b1;
        end
        check("frame_done_within_budget", 64'(seen), 64'(1));
    endtask

    task automatic wait_drive(input int budget);
        int k    = 0;
        bit seen = 1'b0;
        while (k < budget && !seen) begin
            @(negedge clk);
            k++;
            if (row_sel != '1) seen = 1'b1;
        end
        check("row_driven_within_budget", 64'(seen), 64'(1));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row_sel"},    64'(row_sel),    64'hFF);
        check({tag, "_col_data"},   64'(col_data),   64'h0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'h0);
        check({tag, "_gen_count"},  64'(gen_count),  64'h0);
        check({tag, "_still"},      64'(still),      64'h0);
        check({tag, "_extinct"},    64'(extinct),    64'h0);
    endtask

    initial begin
        logic [63:0] last_grid;
        reset_n    = 1'b0;
        grid       = '0;
        grid_valid = 1'b0;
        blank      = 1'b0;
        last_grid  = '0;

        idle(3);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // No generation yet: matrix stays dark, no frames.
        idle(100);

        // First generation: row 0 shows A5, others dark.
        pulse(64'h0000_0000_0000_00A5);
        idle(3);
        // New grid while row 0 is driven: current frame must stay intact.
        pulse(64'h0000_0000_0000_0100);
        wait_frame(60);
        wait_frame(60);

        // Still-life then extinction.
        pulse(64'h1818_0000_0000_0000);
        idle(2);
        pulse(64'h1818_0000_0000_0000);
        check("still_after_repeat", 64'(still), 64'h1);
        idle(2);
        pulse(64'h0);
        check("still_after_change", 64'(still), 64'h0);
        check("extinct_after_zero", 64'(extinct), 64'h1);
        wait_frame(60);

        // Blank a whole frame: timing and frame_done continue.
        pulse(64'hFFFF_FFFF_FFFF_FFFF);
        wait_frame(60);
        blank = 1'b1;
        wait_frame(60);
        blank = 1'b0;
        wait_frame(60);

        // Random traffic: sparse pulses, occasional repeats/zeros, blank toggles.
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            grid_valid = ($urandom_range(0, 11) == 0);
            case ($urandom_range(0, 5))
                0:       grid = last_grid;
                1:       grid = 64'h0;
                default: grid = {$urandom(), $urandom()};
            endcase
            if (grid_valid) last_grid = grid;
            if ($urandom_range(0, 9) == 0) blank = ~blank;
        end
        @(negedge clk);
        grid_valid = 1'b0;
        blank      = 1'b0;
        wait_frame(60);

        // Asynchronous reset in the middle of a driven row.
        wait_drive(60);
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("async_reset");
        idle(3);
        reset_n = 1'b1;
        idle(60);

        // Empty first grid after reset compares equal to the cleared buffer;
        // gen_count saturates at its width.
        pulse(64'h0);
        check("gen_after_pulse1", 64'(gen_count), 64'd1);
        check("still_first_empty", 64'(still), 64'h1);
        check("extinct_first_empty", 64'(extinct), 64'h1);
        for (int i = 2; i <= 5; i++) begin
            idle(7);
            pulse({$urandom(), $urandom()} | 64'h1);
            check($sformatf("gen_after_pulse%0d", i), 64'(gen_count),
                  64'((i < GENMAX) ? i : GENMAX));
        end
        wait_frame(60);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
